keypad_scan: RTL and testbench
==============================

Name: keypad_scan

Overview:
Scanner and debouncer for a 4x4 matrix keypad (Pmod KYPD style, active-low column strobes, active-low row returns with pull-ups).
- Drives one column low at a time, samples the rows and assembles a 16-key frame.
- Debounces at frame level and reports each new key press as a single-cycle event carrying the hex legend of the key.
- It is the input-side counterpart of the multiplexed 7-segment driver. Its key_code feeds the display data path directly.

Parameters:
- SCAN_RLD, 99_999: prescaler reload. A column is active for SCAN_RLD+1 clocks (1 ms at 100 MHz).
- SCAN_RLD_TURBOSIM, 9: reload used when turbosim=1.
- DEBOUNCE_SCANS, 15: number of consecutive identical frames required before a frame is committed.
- DEBOUNCE_SCANS_TURBOSIM, 2: value used when turbosim=1.
- REPEAT_SCANS, 250: frames between auto-repeat events. Used only with the optional feature.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- turbosim  in  1  selects the *_TURBOSIM reloads
- en  in  1  scanner enable. 0 behaves as reset.
- rows_n  in  4  row returns, active-low, asynchronous to clk
- cols_n  out  4  column strobes, active-low, one-hot-low while enabled
- key_state  out  16  debounced pressed map, bit index = col*4+row
- key_valid  out  1  one-cycle pulse per new press
- key_code  out  4  hex legend of the reported key, held until the next event

Behaviour:
- Enable and reset
  - scan_en = en & ~reset.
  - While scan_en=0: cols_n=4'hF, key_state=0, key_valid=0, key_code=0. Prescaler, column pointer, frames, debounce count and pending mask are all 0.
  - Reset or en falling mid-frame discards the partial frame. Scanning restarts at column 0.
- Row synchroniser
  - rows_n passes through a 2-FF synchroniser before sampling.
  - Both reloads must be >= 3 so sampled rows have settled after a column change.
- Prescaler
  - Down-counter reloaded from SCAN_RLD or SCAN_RLD_TURBOSIM when it reaches zero. turbosim is sampled at each reload.
  - Width comes from the existing wordlength function.
- Column pointer
  - col ranges 0..3 and drives cols_n = ~(4'b0001<<col).
  - On prescaler zero: raw_frame[col*4 +: 4] <= ~rows_sync, then col increments and wraps 3 to 0.
- Frame complete
  - Occurs on the tick where col=3. The new frame is compared with the previous frame.
  - If equal: stable_cnt increments, saturating at DEBOUNCE. If different: stable_cnt <= 0.
  - When stable_cnt reaches DEBOUNCE (count equal to the active DEBOUNCE value): key_state <= frame, and new presses are ORed into the pending mask.
  - New presses = frame & ~key_state_old.
  - Releases update key_state only and produce no event.
- Event output
  - Each clock with pending != 0: key_valid=1, key_code = KEY_MAP[lowest set index], and that bit is cleared.
  - Simultaneous new presses are therefore emitted lowest index first, on consecutive cycles.
  - If a commit and an emission land on the same cycle, the commit's new bits are merged with the pending bits remaining after the emission.
- KEY_MAP, indexed col*4+row:
  - col0: 1,4,7,0
  - col1: 2,5,8,F
  - col2: 3,6,9,E
  - col3: A,B,C,D
- Latency: a clean press is committed within DEBOUNCE+2 frames. key_valid follows the commit by 1 clock.

Optional Feature:
- Macro: KEYPAD_SCAN_AUTOREPEAT_EN.
- With it:
  - If key_state has exactly one bit set, a repeat counter counts frames. Every REPEAT_SCANS frames that key's bit is re-set in pending, producing another key_valid.
  - The counter clears on any key_state change.
- Without it: no repeat logic. Holding a key gives exactly one event.

Decomposition:
- keypad_pkg:
  - KEY_MAP 16x4 constant
  - key index width
  - column count 4
  - synchroniser depth 2
- Sub-module keypad_debounce:
  - Inputs: frame_valid and frame[15:0].
  - Holds the previous frame and stable_cnt.
  - Outputs: commit strobe and key_state.
- The top level keeps the prescaler, column pointer, synchroniser and pending/event logic.

Test Plan:
The bench models the keypad: rows_n[r]=0 while cols_n[c]=0 and key (c,r) is held. turbosim=1, giving 10 clocks per column and 40 per frame.
1. Reset, en=1, no keys -> cols_n sequence E,D,B,7 with 10 clocks each, repeating. key_valid never asserts. key_state=0.
2. Hold key (1,1) -> exactly one key_valid, key_code=4'h5, key_state=16'h0020, within 4 frames (160 clocks). Release -> key_state=0 and no event.
3. Bounce key (3,2) every 15 clocks for 3 frames, then hold -> no event during bouncing. After settling: one event, key_code=4'hC.
4. Press (0,0) and (2,3) in the same frame -> key_valid on two consecutive clocks, key_code 4'h1 then 4'hE. key_state=16'h0801.
5. Assert reset mid-column-2 while a key is committed -> next clock: cols_n=F, key_state=0, key_valid=0. After release, scanning restarts at column 0.
6. With KEYPAD_SCAN_AUTOREPEAT_EN and REPEAT_SCANS=3, hold key (2,0) -> key_code 4'h3 first, then repeats every 3 frames (120 clocks). A second key pressed -> repeats stop.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared constants for the 4x4 keypad scanner: key legend map, widths,
// synchroniser depth and the wordlength helper used to size counters.
package keypad_pkg;

  localparam int NUM_COLS   = 4;
  localparam int NUM_ROWS   = 4;
  localparam int NUM_KEYS   = NUM_COLS * NUM_ROWS;
  localparam int KEY_IDX_W  = 4;
  localparam int SYNC_DEPTH = 2;

  // Hex legend printed on each key, indexed col*4+row.
  localparam logic [3:0] KEY_MAP [NUM_KEYS] = '{
    4'h1, 4'h4, 4'h7, 4'h0,
    4'h2, 4'h5, 4'h8, 4'hF,
    4'h3, 4'h6, 4'h9, 4'hE,
    4'hA, 4'hB, 4'hC, 4'hD
  };

  // Number of bits needed to hold 'value' (at least 1).
  function automatic int wordlength(input int unsigned value);
    int w;
    w = 1;
    for (int i = 1; i < 32; i++) begin
      if ((value >> i) != 0) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Frame-level debouncer: a frame is committed to key_state once it has been
// seen unchanged for the active DEBOUNCE count of consecutive frames.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_SCANS          = 15,
  parameter int DEBOUNCE_SCANS_TURBOSIM = 2
) (
  input  logic                clk,
  input  logic                clear,
  input  logic                turbosim,
  input  logic                frame_valid,
  input  logic [NUM_KEYS-1:0] frame,
  output logic                commit,
  output logic [NUM_KEYS-1:0] key_state
);

  localparam int DEB_MAX = (DEBOUNCE_SCANS > DEBOUNCE_SCANS_TURBOSIM) ?
                           DEBOUNCE_SCANS : DEBOUNCE_SCANS_TURBOSIM;
  localparam int CNT_W   = wordlength(DEB_MAX);

  logic [CNT_W-1:0]    deb;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NUM_KEYS-1:0] prev_q, prev_d;
  logic [NUM_KEYS-1:0] state_q, state_d;

  // Compare each complete frame with the previous one and commit when stable.
  always_comb begin
    deb     = turbosim ? CNT_W'(DEBOUNCE_SCANS_TURBOSIM) : CNT_W'(DEBOUNCE_SCANS);
    cnt_d   = cnt_q;
    prev_d  = prev_q;
    state_d = state_q;
    commit  = 1'b0;
    if (frame_valid) begin
      prev_d = frame;
      if (frame == prev_q) begin
        cnt_d = (cnt_q >= deb) ? deb : cnt_q + 1'b1;
        if (cnt_d == deb) begin
          commit  = 1'b1;
          state_d = frame;
        end
      end else begin
        cnt_d = '0;
      end
    end
  end

  // Debounce state; cleared whenever scanning is disabled.
  always_ff @(posedge clk) begin
    if (clear) begin
      cnt_q   <= '0;
      prev_q  <= '0;
      state_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      prev_q  <= prev_d;
      state_q <= state_d;
    end
  end

  assign key_state = state_q;

endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: strobes one column low at a time, samples the
// synchronised rows into a 16-key frame, debounces it and emits one
// key_valid/key_code event per new press (lowest key index first).
// Build option: define KEYPAD_SCAN_AUTOREPEAT_EN to re-emit a single held
// key every REPEAT_SCANS frames.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_RLD                = 99_999,
  parameter int SCAN_RLD_TURBOSIM       = 9,
  parameter int DEBOUNCE_SCANS          = 15,
  parameter int DEBOUNCE_SCANS_TURBOSIM = 2,
  parameter int REPEAT_SCANS            = 250
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                turbosim,
  input  logic                en,
  input  logic [NUM_ROWS-1:0] rows_n,
  output logic [NUM_COLS-1:0] cols_n,
  output logic [NUM_KEYS-1:0] key_state,
  output logic                key_valid,
  output logic [3:0]          key_code
);

  localparam int PRE_W = wordlength((SCAN_RLD > SCAN_RLD_TURBOSIM) ?
                                    SCAN_RLD : SCAN_RLD_TURBOSIM);

  logic                 scan_en;
  logic [NUM_ROWS-1:0]  sync_q [SYNC_DEPTH];
  logic [NUM_ROWS-1:0]  sync_d [SYNC_DEPTH];
  logic [PRE_W-1:0]     pre_q, pre_d;
  logic [1:0]           col_q, col_d;
  logic [NUM_KEYS-1:0]  frame_q, frame_d;
  logic [NUM_KEYS-1:0]  pending_q, pending_d;
  logic [3:0]           code_q, code_d;
  logic                 tick;
  logic                 frame_valid;
  logic                 commit;
  logic [NUM_KEYS-1:0]  state_db;
  logic [NUM_KEYS-1:0]  repeat_set;
  logic [KEY_IDX_W-1:0] emit_idx;
  logic                 emit;

  assign scan_en = en & ~reset;

  // Row synchroniser chain, prescaler, column pointer and frame assembly.
  always_comb begin
    sync_d[0] = rows_n;
    for (int i = 1; i < SYNC_DEPTH; i++) sync_d[i] = sync_q[i-1];
    tick        = (pre_q == '0);
    pre_d       = tick ? (turbosim ? PRE_W'(SCAN_RLD_TURBOSIM) : PRE_W'(SCAN_RLD))
                       : pre_q - 1'b1;
    col_d       = tick ? col_q + 2'd1 : col_q;
    frame_d     = frame_q;
    if (tick) frame_d[{col_q, 2'b00} +: NUM_ROWS] = ~sync_q[SYNC_DEPTH-1];
    frame_valid = tick && (col_q == 2'd3);
  end

  // Scan state registers; disabling the scanner discards any partial frame.
  always_ff @(posedge clk) begin
    if (!scan_en) begin
      for (int i = 0; i < SYNC_DEPTH; i++) sync_q[i] <= '1;
      pre_q   <= '0;
      col_q   <= '0;
      frame_q <= '0;
    end else begin
      for (int i = 0; i < SYNC_DEPTH; i++) sync_q[i] <= sync_d[i];
      pre_q   <= pre_d;
      col_q   <= col_d;
      frame_q <= frame_d;
    end
  end

  keypad_debounce #(
    .DEBOUNCE_SCANS          (DEBOUNCE_SCANS),
    .DEBOUNCE_SCANS_TURBOSIM (DEBOUNCE_SCANS_TURBOSIM)
  ) u_debounce (
    .clk         (clk),
    .clear       (~scan_en),
    .turbosim    (turbosim),
    .frame_valid (frame_valid),
    .frame       (frame_d),
    .commit      (commit),
    .key_state   (state_db)
  );

`ifdef KEYPAD_SCAN_AUTOREPEAT_EN
  localparam int REP_W = wordlength(REPEAT_SCANS);

  logic [REP_W-1:0] rep_q, rep_d;

  // Count frames while exactly one key is held; re-arm it every REPEAT_SCANS frames.
  always_comb begin
    rep_d      = rep_q;
    repeat_set = '0;
    if ((commit && (frame_d != state_db)) || !$onehot(state_db)) begin
      rep_d = '0;
    end else if (frame_valid) begin
      if (rep_q >= REP_W'(REPEAT_SCANS - 1)) begin
        rep_d      = '0;
        repeat_set = state_db;
      end else begin
        rep_d = rep_q + 1'b1;
      end
    end
  end

  // Repeat frame counter.
  always_ff @(posedge clk) begin
    if (!scan_en) rep_q <= '0;
    else          rep_q <= rep_d;
  end
`else
  logic [31:0] unused_repeat_scans;
  assign unused_repeat_scans = REPEAT_SCANS;

  // Without auto-repeat a held key produces only its initial event.
  always_comb begin
    repeat_set = '0;
  end
`endif

  // Emit the lowest pending key each cycle and merge in newly committed presses.
  always_comb begin
    emit     = (pending_q != '0);
    emit_idx = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (pending_q[i]) emit_idx = KEY_IDX_W'(i);
    end
    pending_d = pending_q;
    code_d    = code_q;
    if (emit) begin
      pending_d[emit_idx] = 1'b0;
      code_d              = KEY_MAP[emit_idx];
    end
    if (commit) pending_d = pending_d | (frame_d & ~state_db);
    pending_d = pending_d | repeat_set;
  end

  // Event state registers.
  always_ff @(posedge clk) begin
    if (!scan_en) begin
      pending_q <= '0;
      code_q    <= '0;
    end else begin
      pending_q <= pending_d;
      code_q    <= code_d;
    end
  end

  assign cols_n    = scan_en ? ~(4'b0001 << col_q) : 4'hF;
  assign key_state = scan_en ? state_db : '0;
  assign key_valid = scan_en & emit;
  assign key_code  = scan_en ? code_d : 4'h0;

endmodule

// File: tb/tb_keypad_scan.sv
module tb_keypad_scan;

  logic        clk = 1'b0;
  logic        reset, turbosim, en;
  logic [3:0]  rows_n, cols_n, key_code;
  logic [15:0] key_state;
  logic        key_valid;

  logic [15:0] held;
  logic [15:0] committed;
  int          total  = 0;
  int          passed = 0;
  int          cyc    = 0;
  logic [3:0]  got_q[$];
  int          gcyc_q[$];

  logic [3:0]  prev_cols;
  int          run, nr, g;
  logic [15:0] nset;
  int          nk;

  localparam logic [3:0] LEGEND [16] = '{
    4'h1, 4'h4, 4'h7, 4'h0, 4'h2, 4'h5, 4'h8, 4'hF,
    4'h3, 4'h6, 4'h9, 4'hE, 4'hA, 4'hB, 4'hC, 4'hD
  };
  localparam logic [3:0] EXP_SEQ [8] = '{
    4'hD, 4'hB, 4'h7, 4'hE, 4'hD, 4'hB, 4'h7, 4'hE
  };

  always #5 clk = ~clk;

  keypad_scan #(
    .SCAN_RLD                (99_999),
    .SCAN_RLD_TURBOSIM       (9),
    .DEBOUNCE_SCANS          (15),
    .DEBOUNCE_SCANS_TURBOSIM (2),
    .REPEAT_SCANS            (3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .turbosim  (turbosim),
    .en        (en),
    .rows_n    (rows_n),
    .cols_n    (cols_n),
    .key_state (key_state),
    .key_valid (key_valid),
    .key_code  (key_code)
  );

  // Keypad matrix: a held key pulls its row low while its column is strobed.
  always_comb begin
    rows_n = 4'hF;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (held[c*4+r] && (cols_n[c] === 1'b0)) rows_n[r] = 1'b0;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (key_valid === 1'b1) begin
      got_q.push_back(key_code);
      gcyc_q.push_back(cyc);
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference: a settled key set change yields one event per newly pressed key,
  // in ascending key index, on consecutive cycles; key_state becomes the new set.
  task automatic apply(input logic [15:0] new_set, input string tag);
    logic [3:0] exp_q[$];
    for (int i = 0; i < 16; i++)
      if (new_set[i] && !committed[i]) exp_q.push_back(LEGEND[i]);
    committed = new_set;
    got_q.delete();
    gcyc_q.delete();
    held = new_set;
    repeat (260) step();
    check($sformatf("%s_events", tag), got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s_code%0d", tag, i), got_q[i], exp_q[i]);
    if (got_q.size() > 1)
      check($sformatf("%s_consec", tag), gcyc_q[got_q.size()-1] - gcyc_q[0], got_q.size() - 1);
    check($sformatf("%s_state", tag), key_state, new_set);
  endtask

  initial begin
    reset = 1'b1; en = 1'b1; turbosim = 1'b1; held = '0; committed = '0;
    repeat (5) step();
    check("rst_cols", cols_n, 4'hF);
    check("rst_state", key_state, 16'h0);
    check("rst_valid", key_valid, 1'b0);
    check("rst_code", key_code, 4'h0);

    // 1: idle scanning, column order and dwell
    reset = 1'b0;
    #1;
    check("start_col0", cols_n, 4'hE);
    got_q.delete();
    prev_cols = cols_n; g = 0;
    while (cols_n === prev_cols && g < 50) begin step(); g++; end
    prev_cols = cols_n; run = 1; nr = 0; g = 0;
    while (nr < 8 && g < 200) begin
      step(); g++;
      if (cols_n === prev_cols) run++;
      else begin
        check($sformatf("col_len%0d", nr), run, 10);
        check($sformatf("col_val%0d", nr), prev_cols, EXP_SEQ[nr]);
        nr++; prev_cols = cols_n; run = 1;
      end
    end
    check("seq_done", nr, 8);
    repeat (100) step();
    check("idle_events", got_q.size(), 0);
    check("idle_state", key_state, 16'h0);

`ifdef KEYPAD_SCAN_AUTOREPEAT_EN
    // 6: auto-repeat of a single held key, stopped by a second key
    got_q.delete(); gcyc_q.delete();
    held = 16'h0100;
    g = 0;
    while (got_q.size() < 3 && g < 600) begin step(); g++; end
    check("rep_count", got_q.size() >= 3, 1'b1);
    if (got_q.size() >= 3) begin
      for (int i = 0; i < 3; i++) check($sformatf("rep_code%0d", i), got_q[i], 4'h3);
      check("rep_gap1", gcyc_q[1] - gcyc_q[0], 120);
      check("rep_gap2", gcyc_q[2] - gcyc_q[1], 120);
    end
    held = 16'h0102;
    repeat (200) step();
    check("rep_two_state", key_state, 16'h0102);
    got_q.delete(); gcyc_q.delete();
    repeat (400) step();
    check("rep_stopped", got_q.size(), 0);
`else
    // 2: single press and release
    apply(16'h0020, "press11");
    apply(16'h0000, "release11");

    // 3: bouncing key gives no event until it settles
    got_q.delete();
    for (int k = 0; k < 8; k++) begin
      held[14] = ~held[14];
      repeat (15) step();
    end
    check("bounce_quiet", got_q.size(), 0);
    apply(16'h4000, "settle32");
    apply(16'h0000, "release32");

    // 4: two keys in the same frame
    apply(16'h0801, "dual");
    apply(16'h0000, "release_dual");

    // 5: reset mid column 2 with a key committed
    apply(16'h0040, "pre_rst");
    g = 0;
    while (cols_n !== 4'hB && g < 100) begin step(); g++; end
    check("rst_wait", g < 100, 1'b1);
    repeat (3) step();
    reset = 1'b1;
    held  = '0;
    step();
    check("mid_rst_cols", cols_n, 4'hF);
    check("mid_rst_state", key_state, 16'h0);
    check("mid_rst_valid", key_valid, 1'b0);
    repeat (4) step();
    committed = '0;
    got_q.delete(); gcyc_q.delete();
    reset = 1'b0;
    #1;
    check("restart_col0", cols_n, 4'hE);
    repeat (200) step();
    check("post_rst_events", got_q.size(), 0);

    // randomized key sets against the reference
    for (int it = 0; it < 8; it++) begin
      nset = '0;
      nk = $urandom_range(0, 3);
      for (int j = 0; j < nk; j++) nset[$urandom_range(0, 15)] = 1'b1;
      repeat ($urandom_range(0, 39)) step();
      apply(nset, $sformatf("rand%0d", it));
    end
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
